// File: rtl/led_pkg.sv
// Shared mode constants and FSM state encoding for the LED pattern controller.
package led_pkg;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_SOLID = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_BURST = 2'd3;

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_SOLID     = 3'd1,
    S_BLINK     = 3'd2,
    S_BURST_ON  = 3'd3,
    S_BURST_OFF = 3'd4,
    S_GAP       = 3'd5
  } state_t;

  // A burst in progress may not be interrupted; the gap is a safe switch point.
  function automatic logic cmd_ready_for(input state_t s);
    return !((s == S_BURST_ON) || (s == S_BURST_OFF));
  endfunction

endpackage

// File: rtl/led_sequencer.sv
// Tick-driven LED pattern controller: off, solid, blink and N-pulse burst with gap.
// Commands arrive over valid/ready; patterns advance only on tick_enable cycles.
module led_sequencer
  import led_pkg::*;
#(
  parameter int BURST_W   = 4,
  parameter int GAP_TICKS = 4
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               tick_enable,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_mode,
  input  logic [BURST_W-1:0] cmd_count,
  output logic               led_out,
  output logic [1:0]         mode_o,
  output logic               burst_done
);

  if (GAP_TICKS < 1) begin : g_gap_check
    $error("led_sequencer: GAP_TICKS must be at least 1");
  end

  localparam int                 GAP_W       = $clog2(GAP_TICKS + 1);
  localparam logic [GAP_W-1:0]   GAP_LAST    = GAP_W'(GAP_TICKS - 1);
  localparam logic [BURST_W-1:0] PULSE_FIRST = BURST_W'(1);

  state_t               r_state;
  logic [BURST_W-1:0]   r_pulse_cnt;
  logic [BURST_W-1:0]   r_count;
  logic [GAP_W-1:0]     r_gap_cnt;
  logic                 r_led;
  logic [1:0]           r_mode;
  logic                 r_burst_done;
  logic                 w_accept;

  assign cmd_ready  = cmd_ready_for(r_state);
  assign w_accept   = cmd_valid && cmd_ready;
  assign led_out    = r_led;
  assign mode_o     = r_mode;
  assign burst_done = r_burst_done;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= S_OFF;
      r_pulse_cnt  <= '0;
      r_count      <= '0;
      r_gap_cnt    <= '0;
      r_led        <= 1'b0;
      r_mode       <= MODE_OFF;
      r_burst_done <= 1'b0;
    end else begin
      r_burst_done <= 1'b0;
      // An accepted command takes priority; a coincident tick is dropped.
      if (w_accept) begin
        r_gap_cnt <= '0;
        case (cmd_mode)
          MODE_OFF: begin
            r_state <= S_OFF;
            r_led   <= 1'b0;
            r_mode  <= MODE_OFF;
          end
          MODE_SOLID: begin
            r_state <= S_SOLID;
            r_led   <= 1'b1;
            r_mode  <= MODE_SOLID;
          end
          MODE_BLINK: begin
            r_state <= S_BLINK;
            r_led   <= 1'b1;
            r_mode  <= MODE_BLINK;
          end
          default: begin
            if (cmd_count != '0) begin
              r_count     <= cmd_count;
              r_pulse_cnt <= PULSE_FIRST;
              r_state     <= S_BURST_ON;
              r_led       <= 1'b1;
              r_mode      <= MODE_BURST;
            end else begin
              r_state <= S_OFF;
              r_led   <= 1'b0;
              r_mode  <= MODE_OFF;
            end
          end
        endcase
      end else if (tick_enable) begin
        case (r_state)
          S_BLINK: begin
            r_led <= ~r_led;
          end
          S_BURST_ON: begin
            r_state <= S_BURST_OFF;
            r_led   <= 1'b0;
          end
          S_BURST_OFF: begin
            if (r_pulse_cnt == r_count) begin
              r_state      <= S_GAP;
              r_gap_cnt    <= '0;
              r_burst_done <= 1'b1;
            end else begin
              r_state     <= S_BURST_ON;
              r_pulse_cnt <= r_pulse_cnt + PULSE_FIRST;
              r_led       <= 1'b1;
            end
          end
          S_GAP: begin
            if (r_gap_cnt == GAP_LAST) begin
              r_state     <= S_BURST_ON;
              r_pulse_cnt <= PULSE_FIRST;
              r_led       <= 1'b1;
            end else begin
              r_gap_cnt <= r_gap_cnt + GAP_W'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
